// File: rtl/day_of_month.sv
// day_of_month: calendar day counter with month-length/leap awareness, end-of-month carry and clamp
module day_of_month #(
    parameter int DAY_W  = 5,
    parameter int YEAR_W = 7
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              day_tick,
    input  logic              load,
    input  logic              enable,
    input  logic [DAY_W-1:0]  data,
    input  logic [3:0]        month,
    input  logic [YEAR_W-1:0] year,
    output logic [DAY_W-1:0]  day,
    output logic              month_carry,
    output logic [DAY_W-1:0]  databus
);
    logic [DAY_W-1:0] day_q = DAY_W'(1);
    logic             carry_q = 1'b0;
    logic [DAY_W-1:0] dim;
    logic [DAY_W-1:0] load_val;
    always_comb begin
        dim      = (month == 4'd2) ? ((year[1:0] == 2'b00) ? DAY_W'(29) : DAY_W'(28)) :
                   (month == 4'd4 || month == 4'd6 || month == 4'd9 || month == 4'd11) ? DAY_W'(30) :
                   DAY_W'(31);
        load_val = (data == '0) ? DAY_W'(1) : (data > dim) ? dim : data;
    end
    always_ff @(posedge clk) begin
        if (clear) begin
            day_q   <= DAY_W'(1);
            carry_q <= 1'b0;
        end else if (load) begin
            day_q   <= load_val;
            carry_q <= 1'b0;
        end else if (day_tick) begin
            day_q   <= (day_q >= dim) ? DAY_W'(1) : day_q + DAY_W'(1);
            carry_q <= (day_q >= dim);
        end else begin
            day_q   <= (day_q > dim) ? dim : day_q;
            carry_q <= 1'b0;
        end
    end
    assign day         = day_q;
    assign month_carry = carry_q;
    assign databus     = enable ? day_q : '0;
endmodule
